pe_result_deskew: RTL and testbench

// - Collects diagonally skewed accumulator results from the bottom edge of the PE array.
// - Column c delivers row r of a tile one cycle after column c-1 delivers it.
// - Re-aligns the per-column streams into whole result rows.
// - Emits one row per transfer on a valid/ready stream, with an end-of-tile marker.
// - Sits between pe_controller's result outputs and the output buffer writer.

---
 rtl/pe_pkg.sv | 34 +++
 rtl/pe_col_fifo.sv | 54 +++++
 rtl/pe_result_deskew.sv | 160 ++++++++++++++++
 tb/tb_pe_result_deskew.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared types and helpers for the PE result deskew block.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int C_MAX_TILE_ROWS = 256;
    localparam int C_TILE_ROWS_W   = $clog2(C_MAX_TILE_ROWS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } deskew_state_t;

    // Clamp a signed value into the signed range of an out_w-bit field.
    function automatic logic signed [31:0] sat_narrow(input logic signed [31:0] val,
                                                      input int               out_w);
        logic signed [31:0] w_hi;
        logic signed [31:0] w_lo;
        w_hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        w_lo = -w_hi - 32'sd1;
        if (val > w_hi) begin
            return w_hi;
        end else if (val < w_lo) begin
            return w_lo;
        end
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_col_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pe_col_fifo
// Description : Single-clock per-column FIFO, read data valid in the pop cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_col_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/pe_result_deskew.sv
`default_nettype none
// ============================================================================
// Module      : pe_result_deskew
// Description : Re-aligns diagonally skewed column results into whole rows.
//               Define PE_DESKEW_SAT_EN to saturate instead of truncate.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_result_deskew
    import pe_pkg::*;
#(
    parameter int ARRAY_SIZE             = 8,
    parameter int ACCUMULATOR_DATA_WIDTH = 16,
    parameter int OUT_DATA_WIDTH         = 8,
    parameter int FIFO_DEPTH             = 8,
    parameter int MAX_TILE_ROWS          = C_MAX_TILE_ROWS
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic [$clog2(MAX_TILE_ROWS+1)-1:0]                  tile_rows,
    input  logic [ARRAY_SIZE-1:0]                               in_valid,
    input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]   in_data,
    output logic [ARRAY_SIZE-1:0]                               in_ready,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [ARRAY_SIZE-1:0][OUT_DATA_WIDTH-1:0]           out_data,
    output logic                                                out_last,
    output logic                                                busy,
    output logic                                                done,
    output logic                                                overflow
);

    localparam int TRW = $clog2(MAX_TILE_ROWS + 1);

    deskew_state_t r_state;
    deskew_state_t w_state_nxt;

    logic [TRW-1:0] r_rows;
    logic [TRW-1:0] r_load_cnt;

    logic [ARRAY_SIZE-1:0]                             w_full;
    logic [ARRAY_SIZE-1:0]                             w_empty;
    logic [ARRAY_SIZE-1:0]                             w_push;
    logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0] w_rdata;
    logic [ARRAY_SIZE-1:0][OUT_DATA_WIDTH-1:0]         w_narrow;

    logic                                      r_out_valid;
    logic [ARRAY_SIZE-1:0][OUT_DATA_WIDTH-1:0] r_out_data;
    logic                                      r_out_last;
    logic                                      r_overflow;

    logic w_run;
    logic w_hs;
    logic w_load;
    logic w_ovf_evt;

    assign w_run  = (r_state == RUN);
    assign w_hs   = r_out_valid && out_ready;
    assign w_load = (&(~w_empty)) && (!r_out_valid || out_ready);

    // A full column may still accept when the same cycle pops a row out of it.
    assign w_ovf_evt = w_run && !w_load && (|(in_valid & w_full));

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
        pe_col_fifo #(
            .WIDTH (ACCUMULATOR_DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[c]),
            .pop   (w_load),
            .wdata (in_data[c]),
            .rdata (w_rdata[c]),
            .full  (w_full[c]),
            .empty (w_empty[c])
        );

        assign w_push[c] = w_run && in_valid[c] && (!w_full[c] || w_load);

`ifdef PE_DESKEW_SAT_EN
        logic signed [31:0] w_sat;
        logic               w_unused_sat;
        assign w_sat        = sat_narrow(32'(signed'(w_rdata[c])), OUT_DATA_WIDTH);
        assign w_narrow[c]  = w_sat[OUT_DATA_WIDTH-1:0];
        assign w_unused_sat = ^w_sat[31:OUT_DATA_WIDTH];
`else
        logic w_unused_hi;
        assign w_narrow[c] = w_rdata[c][OUT_DATA_WIDTH-1:0];
        assign w_unused_hi = ^w_rdata[c][ACCUMULATOR_DATA_WIDTH-1:OUT_DATA_WIDTH];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (tile_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_hs && r_out_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows      <= '0;
            r_load_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_rows     <= tile_rows;
                r_load_cnt <= '0;
            end else if (w_load) begin
                r_load_cnt <= r_load_cnt + TRW'(1);
            end

            // Loaded-row index equals handshakes so far, so last is decided at load.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_narrow;
                r_out_last  <= (r_load_cnt == r_rows - TRW'(1));
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end

            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign in_ready  = ~w_full;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pe_result_deskew.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_result_deskew
// Description : Self-checking bench for pe_result_deskew (both narrowing builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_result_deskew;
    import pe_pkg::*;

    localparam int A     = 8;
    localparam int ACC   = 16;
    localparam int OW    = 8;
    localparam int DEPTH = 8;

    logic                     clk       = 1'b0;
    logic                     rst       = 1'b1;
    logic                     start     = 1'b0;
    logic [C_TILE_ROWS_W-1:0] tile_rows = '0;
    logic [A-1:0]             in_valid  = '0;
    logic [A-1:0][ACC-1:0]    in_data   = '0;
    logic [A-1:0]             in_ready;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [A-1:0][OW-1:0]     out_data;
    logic                     out_last;
    logic                     busy;
    logic                     done;
    logic                     overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pe_result_deskew #(
        .ARRAY_SIZE             (A),
        .ACCUMULATOR_DATA_WIDTH (ACC),
        .OUT_DATA_WIDTH         (OW),
        .FIFO_DEPTH             (DEPTH),
        .MAX_TILE_ROWS          (C_MAX_TILE_ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tile_rows (tile_rows),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_narrow(input int v);
`ifdef PE_DESKEW_SAT_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
`else
        int m;
        m = v & 255;
        return (m >= 128) ? m - 256 : m;
`endif
    endfunction

    // Abstract model: column queues, one output slot, a tile state and a row count.
    int mq     [A][DEPTH];
    int mcnt   [A];
    int m_data [A];
    int m_state = 0;   // 0 idle, 1 running, 2 done
    int m_rows  = 0;
    int m_hs    = 0;
    bit m_ov    = 1'b0;
    bit m_last  = 1'b0;
    bit m_ovf   = 1'b0;

    task automatic model_clear();
        for (int c = 0; c < A; c++) begin
            mcnt[c]   = 0;
            m_data[c] = 0;
        end
        m_state = 0;
        m_rows  = 0;
        m_hs    = 0;
        m_ov    = 1'b0;
        m_last  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step();
        bit all_ne;
        bit hs;
        bit pop;
        bit old_last;
        int newidx;
        int front [A];
        old_last = m_last;
        all_ne   = 1'b1;
        for (int c = 0; c < A; c++) if (mcnt[c] == 0) all_ne = 1'b0;
        hs     = m_ov && out_ready;
        pop    = all_ne && (!m_ov || out_ready);
        newidx = m_hs + (hs ? 1 : 0);
        for (int c = 0; c < A; c++) front[c] = 0;
        if (pop) begin
            for (int c = 0; c < A; c++) begin
                front[c] = mq[c][0];
                for (int i = 0; i < DEPTH - 1; i++) mq[c][i] = mq[c][i+1];
                mcnt[c]--;
            end
        end
        if (m_state == 1) begin
            for (int c = 0; c < A; c++) begin
                if (in_valid[c]) begin
                    if (mcnt[c] < DEPTH) begin
                        mq[c][mcnt[c]] = int'($signed(in_data[c]));
                        mcnt[c]++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        if (pop) begin
            m_ov = 1'b1;
            for (int c = 0; c < A; c++) m_data[c] = model_narrow(front[c]);
            m_last = (newidx == m_rows - 1);
        end else if (hs) begin
            m_ov = 1'b0;
        end
        if (hs) m_hs++;
        case (m_state)
            0: if (start) begin
                m_rows  = int'(tile_rows);
                m_hs    = 0;
                m_state = (tile_rows == 0) ? 2 : 1;
            end
            1: if (hs && old_last) m_state = 2;
            default: m_state = 0;
        endcase
    endtask

    always begin
        @(posedge clk or posedge rst);
        if (rst) model_clear();
        else     model_step();
    end

    always begin
        @(negedge clk);
        chk("out_valid", longint'(out_valid), longint'(m_ov));
        chk("busy", longint'(busy), longint'(m_state != 0));
        chk("done", longint'(done), longint'(m_state == 2));
        chk("overflow", longint'(overflow), longint'(m_ovf));
        for (int c = 0; c < A; c++)
            chk($sformatf("in_ready[%0d]", c), longint'(in_ready[c]), longint'(mcnt[c] < DEPTH));
        if (m_ov) begin
            chk("out_last", longint'(out_last), longint'(m_last));
            for (int c = 0; c < A; c++)
                chk($sformatf("out_data[%0d]", c), longint'($signed(out_data[c])), longint'(m_data[c]));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        start    = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // Column c presents row r before edge k when r = k-1-c; rows 0..last_row(c).
    task automatic drive_skew(input int k, input int rows, input bit extra_col0);
        for (int c = 0; c < A; c++) begin
            int r;
            int lim;
            r   = k - 1 - c;
            lim = (extra_col0 && c == 0) ? rows : rows - 1;
            in_valid[c] = (r >= 0 && r <= lim);
            in_data[c]  = ACC'(10 * r + c);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int vals [A];
        int exp5 [A];

        // 1: reset state, in_valid ignored in IDLE
        do_reset();
        chk("rst out_valid", longint'(out_valid), 0);
        chk("rst in_ready", longint'(in_ready), 255);
        chk("rst busy", longint'(busy), 0);
        chk("rst done", longint'(done), 0);
        chk("rst overflow", longint'(overflow), 0);
        chk("rst out_data", longint'(out_data), 0);
        in_valid = '1;
        for (int c = 0; c < A; c++) in_data[c] = ACC'($urandom_range(0, 65535));
        repeat (3) @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        chk("idle out_valid", longint'(out_valid), 0);
        chk("idle overflow", longint'(overflow), 0);
        chk("idle in_ready", longint'(in_ready), 255);

        // 2: unstalled skewed tile of 4 rows
        out_ready = 1'b1;
        start = 1'b1; tile_rows = 4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            drive_skew(k, 4, 1'b0);
            @(negedge clk);
            if (k == 8) chk("t2 latency", longint'(out_valid), 0);
            if (k >= 9 && k <= 12) begin
                chk("t2 out_valid", longint'(out_valid), 1);
                chk("t2 out_last", longint'(out_last), longint'(k == 12));
                for (int c = 0; c < A; c++)
                    chk("t2 lane", longint'($signed(out_data[c])), longint'(10 * (k - 9) + c));
            end
            if (k == 13) begin
                chk("t2 done", longint'(done), 1);
                chk("t2 out_valid end", longint'(out_valid), 0);
            end
            if (k == 14) chk("t2 done clears", longint'(done), 0);
        end
        in_valid = '0;

        // 3: backpressure, column 0 gets one extra row so it fills
        out_ready = 1'b0;
        start = 1'b1; tile_rows = 8;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            drive_skew(k, 8, 1'b1);
            @(negedge clk);
            if (k == 12) begin
                chk("t3 col0 full", longint'(in_ready[0]), 0);
                chk("t3 col7 ready", longint'(in_ready[7]), 1);
            end
            if (k == 20 || k == 30) begin
                chk("t3 held valid", longint'(out_valid), 1);
                for (int c = 0; c < A; c++)
                    chk("t3 held lane", longint'($signed(out_data[c])), longint'(c));
            end
        end
        in_valid  = '0;
        out_ready = 1'b1;
        idx = 0;
        for (int k = 0; k < 40 && idx < 8; k++) begin
            if (out_valid) begin
                for (int c = 0; c < A; c++)
                    chk("t3 drain lane", longint'($signed(out_data[c])), longint'(10 * idx + c));
                chk("t3 drain last", longint'(out_last), longint'(idx == 7));
                idx++;
            end
            @(negedge clk);
        end
        chk("t3 rows drained", longint'(idx), 8);
        chk("t3 done", longint'(done), 1);

        // 4: overflow on column 0
        do_reset();
        start = 1'b1; tile_rows = 16;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 8'h01;
            in_data[0] = ACC'(100 + i);
            @(negedge clk);
            if (i == 7) chk("t4 no overflow yet", longint'(overflow), 0);
            if (i == 8) chk("t4 overflow", longint'(overflow), 1);
        end
        in_valid = '0;
        start = 1'b1; tile_rows = 3;
        @(negedge clk);
        start = 1'b0;
        chk("t4 overflow after start", longint'(overflow), 1);
        chk("t4 start ignored", longint'(busy), 1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 8'hFE;
            for (int c = 1; c < A; c++) in_data[c] = ACC'(20 + i);
            @(negedge clk);
        end
        in_valid  = '0;
        out_ready = 1'b1;
        idx = 0;
        for (int k = 0; k < 20 && idx < 8; k++) begin
            if (out_valid) begin
                chk("t4 preserved", longint'($signed(out_data[0])), longint'(100 + idx));
                idx++;
            end
            @(negedge clk);
        end
        chk("t4 rows", longint'(idx), 8);
        do_reset();
        chk("t4 overflow cleared", longint'(overflow), 0);

        // 5: narrowing
        vals = '{300, -300, 127, -128, 0, 1, -1, 255};
`ifdef PE_DESKEW_SAT_EN
        exp5 = '{127, -128, 127, -128, 0, 1, -1, 127};
`else
        exp5 = '{44, -44, 127, -128, 0, 1, -1, -1};
`endif
        out_ready = 1'b1;
        start = 1'b1; tile_rows = 1;
        @(negedge clk);
        start = 1'b0;
        in_valid = '1;
        for (int c = 0; c < A; c++) in_data[c] = ACC'(vals[c]);
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        chk("t5 out_valid", longint'(out_valid), 1);
        chk("t5 out_last", longint'(out_last), 1);
        for (int c = 0; c < A; c++)
            chk($sformatf("t5 lane%0d", c), longint'($signed(out_data[c])), longint'(exp5[c]));
        @(negedge clk);
        chk("t5 done", longint'(done), 1);

        // 6a: zero-row tile
        @(negedge clk);
        start = 1'b1; tile_rows = 0;
        @(negedge clk);
        start = 1'b0;
        chk("t6 zero done", longint'(done), 1);
        chk("t6 zero out_valid", longint'(out_valid), 0);
        @(negedge clk);
        chk("t6 zero done clears", longint'(done), 0);
        chk("t6 zero idle", longint'(busy), 0);

        // 6b: reset after two of four rows
        start = 1'b1; tile_rows = 4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            drive_skew(k, 4, 1'b0);
            @(negedge clk);
        end
        do_reset();
        chk("t6 rst busy", longint'(busy), 0);
        chk("t6 rst in_ready", longint'(in_ready), 255);
        chk("t6 rst out_valid", longint'(out_valid), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6 rst no done", longint'(done), 0);
        end

        // 6c: single-row tile
        out_ready = 1'b1;
        start = 1'b1; tile_rows = 1;
        @(negedge clk);
        start = 1'b0;
        in_valid = '1;
        for (int c = 0; c < A; c++) in_data[c] = ACC'(7 * c);
        @(negedge clk);
        in_valid = '0;
        @(negedge clk);
        chk("t6 one valid", longint'(out_valid), 1);
        chk("t6 one last", longint'(out_last), 1);
        chk("t6 one lane7", longint'($signed(out_data[7])), 49);
        @(negedge clk);
        chk("t6 one done", longint'(done), 1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
